// File: rtl/psec6_readout_sequencer.sv
// psec6_readout_sequencer
//
// Walks the enabled channel digital blocks in index order and, for each one,
// reads NUM_REGS registers of WORD_BITS bits each, muxing the selected
// channel's serial line onto a single output toward the chip MISO.
//
// Ports
//   spi_clk       sole clock, rising edge
//   rstb          asynchronous active-low reset
//   read_req      start request, sampled only while idle
//   abort         synchronous abort of an in-progress readout
//   ch_mask       1 = channel included (captured when a readout starts)
//   cnt_ser       serial data from each channel, MSB first
//   inst_readout  one-hot load strobe to the selected channel (LOAD cycle)
//   select_reg    register select broadcast to all channels
//   data_out      serial payload bit
//   data_valid    data_out carries a payload bit
//   word_start    marks the first (MSB) bit of each word
//   ch_id         index of the channel being read
//   busy          readout in progress
//   done          one-cycle pulse when a readout completes or aborts
//   state_dbg     current FSM state
//
// Output stream: data_out is meaningful only in cycles where data_valid is 1
// and is held at 0 otherwise; word_start is only ever 1 together with
// data_valid. There is no backpressure: the consumer must take one bit per
// valid cycle.
module psec6_readout_sequencer #(
  parameter int NUM_CH    = 8,
  parameter int WORD_BITS = 10,
  parameter int NUM_REGS  = 6
) (
  input  logic              spi_clk,
  input  logic              rstb,
  input  logic              read_req,
  input  logic              abort,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [NUM_CH-1:0] cnt_ser,
  output logic [NUM_CH-1:0] inst_readout,
  output logic [2:0]        select_reg,
  output logic              data_out,
  output logic              data_valid,
  output logic              word_start,
  output logic [2:0]        ch_id,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state_dbg
);

  // The pointer carries one extra bit so that stepping past the last channel
  // is seen as ptr == NUM_CH instead of wrapping back to channel 0.
  localparam int PTR_W = $clog2(NUM_CH + 1);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BIT_W = $clog2(WORD_BITS + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SCAN  = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

  logic [2:0]        state;
  logic [PTR_W-1:0]  ptr;
  logic [CH_W-1:0]   ptr_lo;
  logic [2:0]        reg_idx;
  logic [BIT_W-1:0]  bit_cnt;
  logic [NUM_CH-1:0] mask_q;
  logic [NUM_CH-1:0] ptr_onehot;

  // Only used to index channels while ptr < NUM_CH.
  assign ptr_lo     = ptr[CH_W-1:0];
  assign ptr_onehot = {{(NUM_CH-1){1'b0}}, 1'b1} << ptr_lo;
  assign state_dbg  = state;

  always_ff @(posedge spi_clk or negedge rstb) begin
    if (!rstb) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      reg_idx      <= '0;
      bit_cnt      <= '0;
      mask_q       <= '0;
      inst_readout <= '0;
      select_reg   <= '0;
      data_out     <= 1'b0;
      data_valid   <= 1'b0;
      word_start   <= 1'b0;
      ch_id        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      // Strobes and pulses last a single cycle unless re-asserted below.
      inst_readout <= '0;
      word_start   <= 1'b0;
      done         <= 1'b0;

      // FIN is already winding down, so abort there just lets it finish.
      if (abort && state != ST_IDLE && state != ST_FIN) begin
        state      <= ST_FIN;
        done       <= 1'b1;
        data_valid <= 1'b0;
        data_out   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (read_req) begin
              state   <= ST_SCAN;
              busy    <= 1'b1;
              ptr     <= '0;
              reg_idx <= '0;
              bit_cnt <= '0;
              mask_q  <= ch_mask;
            end
          end

          ST_SCAN: begin
            if (ptr >= PTR_W'(NUM_CH)) begin
              state <= ST_FIN;
              done  <= 1'b1;
            end else if (mask_q[ptr_lo]) begin
              state        <= ST_LOAD;
              inst_readout <= ptr_onehot;
              select_reg   <= reg_idx;
              ch_id        <= 3'(ptr_lo);
            end else begin
              ptr <= ptr + PTR_W'(1);
            end
          end

          // The channel presents its MSB while its strobe is high, so the
          // first payload bit is captured on the LOAD -> SHIFT edge.
          ST_LOAD: begin
            state      <= ST_SHIFT;
            bit_cnt    <= '0;
            data_out   <= cnt_ser[ptr_lo];
            data_valid <= 1'b1;
            word_start <= 1'b1;
          end

          ST_SHIFT: begin
            if (bit_cnt == BIT_W'(WORD_BITS - 1)) begin
              data_valid <= 1'b0;
              data_out   <= 1'b0;
              if (reg_idx != 3'(NUM_REGS - 1)) begin
                reg_idx      <= reg_idx + 3'd1;
                select_reg   <= reg_idx + 3'd1;
                inst_readout <= ptr_onehot;
                state        <= ST_LOAD;
              end else begin
                reg_idx <= '0;
                ptr     <= ptr + PTR_W'(1);
                state   <= ST_SCAN;
              end
            end else begin
              bit_cnt  <= bit_cnt + BIT_W'(1);
              data_out <= cnt_ser[ptr_lo];
            end
          end

          ST_FIN: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end

          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/psec6_readout_sequencer.md
PSEC6_READOUT_SEQUENCER -- requirements
Module: psec6_readout_sequencer

Interface
REQ-001 Parameter NUM_CH, default 8, number of channel digital blocks served.
REQ-002 Parameter WORD_BITS, default 10, bits shifted per selected register.
REQ-003 Parameter NUM_REGS, default 6, registers read per channel (SELECT_REG 0..NUM_REGS-1).
REQ-004 SPI_CLK  input  1  sole clock, 40 MHz, rising edge.
REQ-005 RSTB  input  1  asynchronous, active-low full-chip reset.
REQ-006 READ_REQ  input  1  readout request from SPI command decoder, level sampled in IDLE.
REQ-007 ABORT  input  1  synchronous abort of an in-progress readout.
REQ-008 CH_MASK  input  NUM_CH  1 = channel included in readout.
REQ-009 CNT_SER  input  NUM_CH  serial data from each channel digital block, MSB first.
REQ-010 INST_READOUT  output  NUM_CH  one-hot load/readout strobe to the selected channel.
REQ-011 SELECT_REG  output  3  register select broadcast to all channels.
REQ-012 DATA_OUT  output  1  muxed serial data toward chip MISO.
REQ-013 DATA_VALID  output  1  DATA_OUT carries a payload bit.
REQ-014 WORD_START  output  1  one-cycle pulse coincident with first bit of each word.
REQ-015 CH_ID  output  3  index of channel currently read.
REQ-016 BUSY  output  1  readout in progress.
REQ-017 DONE  output  1  one-cycle pulse when sequence completes or aborts.

Function
REQ-018 States: IDLE, SCAN, LOAD, SHIFT, FIN; all outputs registered.
REQ-019 IDLE: READ_REQ=1 at edge -> SCAN next cycle, BUSY=1, reg index=0, channel pointer=0; CH_MASK captured into internal copy at that edge.
REQ-020 SCAN: pointer on masked-in channel -> LOAD; masked-out -> pointer+1, remain SCAN (one cycle per skipped channel); pointer past NUM_CH-1 -> FIN.
REQ-021 LOAD: one cycle; INST_READOUT bit [pointer]=1, all others 0; SELECT_REG = reg index; CH_ID = pointer; -> SHIFT.
REQ-022 SHIFT: WORD_BITS cycles; DATA_OUT = CNT_SER[pointer] registered; DATA_VALID=1; WORD_START=1 on first bit only; SELECT_REG held stable.
REQ-023 After last bit: reg index < NUM_REGS-1 -> reg index+1, LOAD; else reg index=0, pointer+1, SCAN.
REQ-024 Register order per channel: SELECT_REG 0 = trigger_cnt (zero-extended to WORD_BITS by channel), 1..5 = CA..CE.
REQ-025 Cost per enabled channel = NUM_REGS*(1+WORD_BITS) = 66 cycles; per skipped channel = 1 SCAN cycle.
REQ-026 FIN: one cycle, DONE=1, BUSY=0 on next cycle, -> IDLE; READ_REQ in FIN ignored.
REQ-027 READ_REQ during SCAN/LOAD/SHIFT ignored; CH_MASK changes mid-sequence ignored (captured copy used).
REQ-028 CH_MASK all zero: SCAN traverses NUM_CH cycles then FIN; no INST_READOUT, DATA_VALID never asserted.
REQ-029 ABORT=1 in any non-IDLE state -> FIN next cycle; DATA_VALID, INST_READOUT, WORD_START forced 0 that cycle; ABORT in IDLE no effect.
REQ-030 Bit counter width ceil(log2(WORD_BITS+1)); pointer width ceil(log2(NUM_CH+1)) so overflow past NUM_CH-1 is detected without wrap.
REQ-031 DATA_OUT = 0 whenever DATA_VALID = 0.

Reset
REQ-032 RSTB=0 asynchronously forces IDLE, all counters 0, INST_READOUT=0, SELECT_REG=0, DATA_OUT=0, DATA_VALID=0, WORD_START=0, CH_ID=0, BUSY=0, DONE=0.
REQ-033 Reset mid-sequence: no DONE pulse; next READ_REQ after RSTB release starts from channel 0, register 0.
REQ-034 RSTB deassertion need not be synchronised inside this block; first READ_REQ honoured at first rising edge after release.

Verification
REQ-035 CH_MASK=0x01, channel 0 models CE=0x3FF, others 0x155, trigger_cnt=5 -> 66 cycles BUSY work, DATA_OUT words 0x005,0x155,0x155,0x155,0x155,0x3FF, DONE one cycle after last bit.
REQ-036 CH_MASK=0xA0 -> SCAN skips 5 channels (5 cycles), reads ch5 (CH_ID=5), 1 skip, reads ch7; INST_READOUT only 0x20 then 0x80; total 5+66+1+66+1 cycles to DONE.
REQ-037 CH_MASK=0x00, READ_REQ pulse -> DONE after 8 SCAN cycles + FIN, DATA_VALID never high.
REQ-038 ABORT asserted on 4th SHIFT bit of ch0 reg 2 -> DONE next cycle, BUSY low after, DATA_VALID 0 from abort cycle, next READ_REQ restarts at ch0 reg0.
REQ-039 RSTB pulled low mid-SHIFT -> all outputs 0 immediately (before next edge), no DONE; repeat REQ-035 passes after release.
REQ-040 READ_REQ held high throughout and CH_MASK toggled mid-run -> exactly one sequence per IDLE entry using the captured mask.
